// File: rtl/apb_multi_timer.sv
// apb_multi_timer
//   NUM_CH independent down-counters on one APB slave. They share one
//   prescaler tick. Each channel runs periodic or one-shot, has a sticky
//   expiry FLAG and a maskable, registered interrupt.
//
//   Optional feature macro: TIMER_PRESCALE_EN
//     defined   : PRESCALE register and prescaler counter exist.
//     undefined : tick every cycle. PRESCALE reads 0 and writes to it are
//                 dropped without an error. No prescaler flops exist.
//
// Ports
//   PCLK              clock, rising edge
//   PRESET            synchronous active-high reset
//   PSEL/PENABLE      APB select / access phase
//   PWRITE            1 = write, 0 = read
//   PADDR             byte address, bits [8:0] decoded
//   PWDATA            write data
//   PRDATA            read data (combinational, 0 unless a valid read)
//   PREADY            constant 1
//   PSLVERR           error on an unmapped or illegal access
//   irq[NUM_CH]       per-channel FLAG & IRQ_EN, registered
//   irq_any           OR of irq
//
// Map
//   0x000 + 16*ch : LOAD (RW), CTRL (RW: EN/ONESHOT/IRQ_EN), COUNT (RO),
//                   STATUS (bit0 FLAG, write 1 to clear)
//   0x100 PRESCALE (RW), 0x104 IRQ_STAT (RO)
module apb_multi_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [NUM_CH-1:0]     irq,
  output logic                  irq_any
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} ch_state_e;

  typedef struct packed {
    logic irq_en;
    logic oneshot;
    logic en;
  } ctrl_t;

  localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

  // ---------------------------------------------------------------- decode
  logic       access, glob, ch_ok, goff_presc, goff_istat, bad, wr_ok;
  logic [3:0] ch_idx;
  logic [1:0] rsel;

  assign access     = PSEL & PENABLE;
  assign glob       = PADDR[8];
  assign ch_idx     = PADDR[7:4];
  assign rsel       = PADDR[3:2];
  assign ch_ok      = {1'b0, ch_idx} < NUM_CH_W;
  assign goff_presc = glob & (PADDR[7:0] == 8'h00);
  assign goff_istat = glob & (PADDR[7:0] == 8'h04);

  // Illegal: missing channel, write to COUNT, write to IRQ_STAT, or any
  // other global offset.
  assign bad = glob ? ~(goff_presc | (goff_istat & ~PWRITE))
                    : (~ch_ok | (PWRITE & (rsel == 2'd2)));

  assign wr_ok   = access & PWRITE & ~bad;
  assign PSLVERR = access & bad;
  assign PREADY  = 1'b1;

  logic unused_addr;
  assign unused_addr = ^PADDR[ADDR_WIDTH-1:9];

  // ------------------------------------------------------------- prescaler
  logic                  tick;
  logic [DATA_WIDTH-1:0] presc_rd;

`ifdef TIMER_PRESCALE_EN
  logic                      wr_presc;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_cnt;

  assign wr_presc = wr_ok & goff_presc;
  assign tick     = (presc_cnt == presc_q);
  assign presc_rd = DATA_WIDTH'(presc_q);

  // A PRESCALE write restarts the count so the new period starts cleanly.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      presc_q   <= '0;
      presc_cnt <= '0;
    end else if (wr_presc) begin
      presc_q   <= PWDATA[PRESCALE_WIDTH-1:0];
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end
`else
  assign tick     = 1'b1;
  assign presc_rd = '0;
`endif

  // -------------------------------------------------------------- channels
  logic  [NUM_CH-1:0][CNT_WIDTH-1:0] load_v, count_v;
  ctrl_t [NUM_CH-1:0]                ctrl_v;
  logic  [NUM_CH-1:0]                flag_v, istat;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e            state_q, state_d;
    logic                 sel, wr_load, wr_ctrl, wr_stat, wr_en1, wr_en0;
    logic                 expire, do_load, do_dec;
    logic                 oneshot_q, irq_en_q, flag_q, irq_q;
    logic [CNT_WIDTH-1:0] load_q, count_q;

    assign sel     = wr_ok & ~glob & (ch_idx == 4'(i));
    assign wr_load = sel & (rsel == 2'd0);
    assign wr_ctrl = sel & (rsel == 2'd1);
    assign wr_stat = sel & (rsel == 2'd3);
    assign wr_en1  = wr_ctrl &  PWDATA[0];
    assign wr_en0  = wr_ctrl & ~PWDATA[0];
    assign expire  = (state_q == S_RUN) & tick & (count_q == '0);

    // FSM: state register
    always_ff @(posedge PCLK) begin
      if (PRESET) state_q <= S_IDLE;
      else        state_q <= state_d;
    end

    // FSM: next state. Software EN writes override hardware; an EN=1 write
    // landing on a one-shot expiry re-arms instead of stopping.
    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:  if (wr_en1) state_d = S_ARM;
        S_ARM:   state_d = S_RUN;
        S_RUN:   if (expire && oneshot_q) state_d = wr_en1 ? S_ARM : S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (wr_en0) state_d = S_IDLE;
    end

    // FSM: outputs. EN=0 freezes COUNT even if a tick lands that cycle.
    always_comb begin
      do_load = 1'b0;
      do_dec  = 1'b0;
      if (!wr_en0) begin
        do_load = (state_q == S_ARM) | (expire & ~oneshot_q);
        do_dec  = (state_q == S_RUN) & tick & (count_q != '0);
      end
    end

    // Datapath. Expiry set beats a same-cycle W1C of FLAG. irq is taken
    // from registered state so APB inputs never reach it combinationally.
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        load_q    <= '0;
        count_q   <= '0;
        oneshot_q <= 1'b0;
        irq_en_q  <= 1'b0;
        flag_q    <= 1'b0;
        irq_q     <= 1'b0;
      end else begin
        if (wr_load) load_q <= PWDATA[CNT_WIDTH-1:0];
        if (wr_ctrl) begin
          oneshot_q <= PWDATA[1];
          irq_en_q  <= PWDATA[2];
        end
        if (do_load)     count_q <= load_q;
        else if (do_dec) count_q <= count_q - 1'b1;
        if (expire)                     flag_q <= 1'b1;
        else if (wr_stat && PWDATA[0])  flag_q <= 1'b0;
        irq_q <= flag_q & irq_en_q;
      end
    end

    assign load_v[i]  = load_q;
    assign count_v[i] = count_q;
    assign ctrl_v[i]  = '{irq_en: irq_en_q, oneshot: oneshot_q,
                          en: (state_q != S_IDLE)};
    assign flag_v[i]  = flag_q;
    assign istat[i]   = flag_q & irq_en_q;
    assign irq[i]     = irq_q;
  end

  assign irq_any = |irq;

  // ------------------------------------------------------------- read mux
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (glob) begin
      if (goff_presc)      rd_data = presc_rd;
      else if (goff_istat) rd_data = DATA_WIDTH'(istat);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == 4'(i)) begin
          case (rsel)
            2'd0:    rd_data = DATA_WIDTH'(load_v[i]);
            2'd1:    rd_data = DATA_WIDTH'(ctrl_v[i]);
            2'd2:    rd_data = DATA_WIDTH'(count_v[i]);
            default: rd_data = DATA_WIDTH'(flag_v[i]);
          endcase
        end
      end
    end
  end

  assign PRDATA = (PSEL && !PWRITE && !bad) ? rd_data : '0;

endmodule

// File: tb/tb_apb_multi_timer.sv
// Bench for apb_multi_timer. Each APB access pushes its expected result
// (read data, PSLVERR, optionally irq) onto a scoreboard queue; a monitor
// pops and compares on every access phase.
module tb_apb_multi_timer;

`ifdef TIMER_PRESCALE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, irq_any;
  logic [3:0]  irq;

  apb_multi_timer dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq(irq), .irq_any(irq_any)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    bit          rd;
    logic [31:0] data;
    bit          err;
    bit          ci;
    logic [3:0]  irq;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;
  bit   drained = 1'b0;

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per access phase.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: unexpected access addr %h", PADDR);
      end else begin
        cur = sb.pop_front();
        chk(cur.name, "pready", 32'(PREADY), 32'd1);
        chk(cur.name, "pslverr", 32'(PSLVERR), 32'(cur.err));
        if (cur.rd) chk(cur.name, "prdata", PRDATA, cur.data);
        if (cur.ci) begin
          chk(cur.name, "irq", 32'(irq), 32'(cur.irq));
          chk(cur.name, "irq_any", 32'(irq_any), 32'(|cur.irq));
        end
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      chk("end", "sb_left", 32'(sb.size()), 32'd0);
    end
  end

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp, input bit err, input string name,
                     input bit ci, input logic [3:0] eirq);
    exp_t e;
    e.name = name; e.rd = !wr; e.data = exp; e.err = err; e.ci = ci; e.irq = eirq;
    sb.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp,
                    input bit err = 1'b0, input bit ci = 1'b0, input logic [3:0] eirq = 4'h0);
    apb(1'b0, addr, 32'h0, exp, err, name, ci, eirq);
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input bit err = 1'b0, input bit ci = 1'b0, input logic [3:0] eirq = 4'h0);
    apb(1'b1, addr, data, 32'h0, err, name, ci, eirq);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset state: every mapped register reads 0, no interrupts.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        rd($sformatf("rst_c%0d_r%0d", c, r), 32'(c * 16 + r * 4), 32'h0, 1'b0, 1'b1, 4'h0);
    rd("rst_presc", 32'h100, 32'h0);
    rd("rst_istat", 32'h104, 32'h0, 1'b0, 1'b1, 4'h0);

    // ch0 periodic LOAD=3, IRQ_EN. Reads land every 2 cycles after the
    // CTRL write edge W: W+1=3, W+3=1, W+5=3 (reload), W+7=1, then after
    // one idle W+10=2, W+12=0. irq follows FLAG (set at W+5) one cycle late.
    wr("c0_load", 32'h000, 32'd3);
    wr("c0_ctrl", 32'h004, 32'h5);
    rd("c0_cnt_a", 32'h008, 32'd3);
    rd("c0_cnt_b", 32'h008, 32'd1);
    rd("c0_cnt_c", 32'h008, 32'd3, 1'b0, 1'b1, 4'h0);
    rd("c0_cnt_d", 32'h008, 32'd1, 1'b0, 1'b1, 4'h1);
    idle(1);
    rd("c0_cnt_e", 32'h008, 32'd2);
    rd("c0_cnt_f", 32'h008, 32'd0);
    rd("c0_stat", 32'h00C, 32'd1, 1'b0, 1'b1, 4'h1);
    rd("c0_istat", 32'h104, 32'd1);
    // EN=0 at W+19 freezes COUNT at 2 (reloaded at W+17, decremented W+18).
    wr("c0_stop", 32'h004, 32'h4);
    rd("c0_frozen", 32'h008, 32'd2);
    wr("c0_w1c", 32'h00C, 32'd1, 1'b0, 1'b1, 4'h1);
    rd("c0_stat_clr", 32'h00C, 32'd0, 1'b0, 1'b1, 4'h0);
    rd("c0_istat_clr", 32'h104, 32'd0);
    rd("c0_ctrl_rd", 32'h004, 32'h4);

    // ch1 one-shot LOAD=2 with PRESCALE=4: ticks every 5 cycles after the
    // PRESCALE write edge P, so COUNT reads (P+3..P+11) are 2,1,1,1,0.
    // Without the prescaler ticks are every cycle: 2,0,0,0,0.
    wr("c1_load", 32'h010, 32'd2);
    wr("presc4", 32'h100, 32'd4);
    wr("c1_ctrl", 32'h014, 32'h3);
    rd("c1_cnt_a", 32'h018, 32'd2);
    rd("c1_cnt_b", 32'h018, PRE_EN ? 32'd1 : 32'd0);
    rd("c1_cnt_c", 32'h018, PRE_EN ? 32'd1 : 32'd0);
    rd("c1_cnt_d", 32'h018, PRE_EN ? 32'd1 : 32'd0);
    rd("c1_cnt_e", 32'h018, 32'd0);
    idle(10);
    rd("c1_ctrl_done", 32'h014, 32'h2);
    rd("c1_cnt_done", 32'h018, 32'd0);
    rd("c1_stat", 32'h01C, 32'd1, 1'b0, 1'b1, 4'h0);
    rd("c1_istat", 32'h104, 32'd0);
    rd("presc_rd", 32'h100, PRE_EN ? 32'd4 : 32'd0);

    // ch2 periodic LOAD=3: expiry on the 5th edge after CTRL; a W1C lands
    // on exactly that edge and FLAG must still read 1.
    wr("presc0", 32'h100, 32'd0);
    wr("c2_load", 32'h020, 32'd3);
    wr("c2_ctrl", 32'h024, 32'h1);
    idle(3);
    wr("c2_w1c_exp", 32'h02C, 32'd1);
    rd("c2_stat_set", 32'h02C, 32'd1);

    // ch3 one-shot LOAD=1: expiry at B+3 coincides with an EN=1 write, so
    // the channel re-arms: COUNT=1 at B+4, expires again at B+6.
    wr("c3_load", 32'h030, 32'd1);
    wr("c3_ctrl", 32'h034, 32'h3);
    idle(1);
    wr("c3_rearm", 32'h034, 32'h3);
    rd("c3_cnt_rearm", 32'h038, 32'd1);
    rd("c3_ctrl_end", 32'h034, 32'h2);
    rd("c3_stat", 32'h03C, 32'd1);

    // Illegal accesses.
    rd("err_rd_ch15", 32'h0F0, 32'h0, 1'b1);
    wr("err_wr_cnt", 32'h008, 32'h55, 1'b1);
    rd("c0_cnt_kept", 32'h008, 32'd2);
    rd("err_rd_108", 32'h108, 32'h0, 1'b1);
    wr("err_wr_istat", 32'h104, 32'hF, 1'b1);
    rd("err_rd_1fc", 32'h1FC, 32'h0, 1'b1);
    wr("err_wr_ch15", 32'h0F4, 32'h1, 1'b1);
    rd("c3_load_kept", 32'h030, 32'd1);

    // Reset in the middle of two running channels (ch0, ch2).
    wr("c0_restart", 32'h004, 32'h5);
    idle(6);
    rd("c0_pre_rst", 32'h00C, 32'd1, 1'b0, 1'b1, 4'h1);
    PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
    rd("rst2_c0_cnt", 32'h008, 32'd0, 1'b0, 1'b1, 4'h0);
    rd("rst2_c0_ctrl", 32'h004, 32'd0);
    rd("rst2_c2_cnt", 32'h028, 32'd0);
    rd("rst2_c2_ctrl", 32'h024, 32'd0);
    rd("rst2_c2_stat", 32'h02C, 32'd0, 1'b0, 1'b1, 4'h0);
    rd("rst2_c0_load", 32'h000, 32'd0);

    // PRESCALE write/readback; without the prescaler it is dropped silently.
    wr("presc7", 32'h100, 32'd7);
    rd("presc7_rd", 32'h100, PRE_EN ? 32'd7 : 32'd0);

    idle(2);
    done = 1'b1;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
